// File: rtl/uart_rx_fifo_if.sv
// FIFO read port and receiver status of uart_rx_fifo, grouped for the consumer.
// master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 RdEn;
    logic [DATA_BITS-1:0] RdData;
    logic                 Empty;
    logic                 Full;
    logic [CNT_W-1:0]     Count;
    logic                 Busy;
    logic                 FrameErr;
    logic                 ParityErr;
    logic                 Overrun;
    logic [2:0]           DbgState;

    // Read handshake: a pop happens on any clock where RdEn is high and Empty is low.
    // RdData shows the FIFO head whenever Empty is low; RdEn while Empty is ignored.
    modport master (
        input  RdEn,
        output RdData, Empty, Full, Count, Busy, FrameErr, ParityErr, Overrun, DbgState
    );

    modport slave (
        output RdEn,
        input  RdData, Empty, Full, Count, Busy, FrameErr, ParityErr, Overrun, DbgState
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver, 16x oversampling with glitch-rejecting start detect, feeding a FWFT receive FIFO.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             CLK_100MHz,
    input  logic             Reset,
    input  logic             Rx,
    uart_rx_fifo_if.master   rx_if
);
    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_fifo: CLK_HZ/(BAUD*16) must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_rx_fifo: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                 rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0]     div_q;
    logic                 tick;

    state_t               state_q, state_d;
    logic [3:0]           smp_q, smp_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic [DATA_BITS-1:0] push_data_q, push_data_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 pflag_q, pflag_d;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 fifo_full, fifo_empty, do_pop, do_push;

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
        end else if (div_q == DIV_W'(DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            smp_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
            pflag_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q      <= perr_d;
            pflag_q     <= pflag_d;
`endif
        end
    end

    // Samples land on tick 8 of the start bit, then every 16 ticks: mid-point of each bit.
    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d      = perr_q;
        pflag_d     = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        state_d = S_START;
                        smp_d   = '0;
                    end
                end
                S_START: begin
                    if (smp_q == 4'd7) begin
                        smp_d = '0;
                        bit_d = '0;
                        state_d = rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (smp_q == 4'd15) begin
                        smp_d   = '0;
                        shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (smp_q == 4'd15) begin
                        smp_d   = '0;
                        perr_d  = ((^shift_q) ^ rx_sync_q) != (PARITY_ODD != 0);
                        state_d = S_STOP;
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (smp_q == 4'd15) begin
                        smp_d  = '0;
                        ferr_d = !rx_sync_q;
`ifdef UART_RX_PARITY_EN
                        pflag_d = perr_q;
                        push_d  = rx_sync_q && !perr_q;
`else
                        push_d  = rx_sync_q;
`endif
                        push_data_d = shift_q;
                        state_d     = rx_sync_q ? S_IDLE : S_BREAK;
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_pop     = rx_if.RdEn && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push    = push_q && (!fifo_full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_q;
        end
    end

    assign rx_if.RdData   = fifo_empty ? '0 : mem[rd_ptr_q];
    assign rx_if.Empty    = fifo_empty;
    assign rx_if.Full     = fifo_full;
    assign rx_if.Count    = count_q;
    assign rx_if.Busy     = (state_q != S_IDLE);
    assign rx_if.FrameErr = ferr_q;
    assign rx_if.Overrun  = push_q && !do_push;
    assign rx_if.DbgState = state_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.ParityErr = pflag_q;
`else
    assign rx_if.ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives serial frames and compares the FIFO against a queue model.
// Runs at a fast baud (DIV 4) to keep frames short.
module tb_uart_rx_fifo;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_562_500;
  localparam int DB     = 8;
  localparam int DEPTH  = 16;
  localparam int PODD   = 0;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * DIV;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) ifc ();

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .CLK_100MHz(clk),
    .Reset(rst),
    .Rx(rx),
    .rx_if(ifc)
  );

  int total = 0;
  int bad = 0;
  int ferr_n = 0;
  int perr_n = 0;
  int ovr_n = 0;
  int exp_ovr = 0;
  logic [DB-1:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
  bit par_flip = 1'b0;
`endif

  always @(negedge clk) begin
    if (ifc.FrameErr === 1'b1) ferr_n++;
    if (ifc.ParityErr === 1'b1) perr_n++;
    if (ifc.Overrun === 1'b1) ovr_n++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [DB-1:0] d);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_clks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = ((^d) ^ (PODD != 0)) ^ par_flip;
    wait_clks(BIT);
`endif
  endtask

  task automatic send_frame(input logic [DB-1:0] d);
    send_head(d);
    rx = 1'b1;
    wait_clks(BIT);
  endtask

  // Reference model: a good frame enters the queue unless it already holds DEPTH bytes.
  task automatic model_rx(input logic [DB-1:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    ifc.RdEn = 1'b0;
    wait_clks(3);
    total++; if (ifc.Empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", ifc.Empty); end
    total++; if (ifc.Full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", ifc.Full); end
    total++; if (ifc.Count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ifc.Count); end
    total++; if (ifc.RdData !== 8'h00) begin bad++; $display("FAIL reset_rddata got=%h want=00", ifc.RdData); end
    total++; if ({ifc.Busy, ifc.FrameErr, ifc.ParityErr, ifc.Overrun} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {ifc.Busy, ifc.FrameErr, ifc.ParityErr, ifc.Overrun});
    end
    rst = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_single();
    int n;
    int f0;
    f0 = ferr_n + perr_n + ovr_n;
    send_head(8'hA5);
    rx = 1'b1;
    n = 0;
    while (ifc.Empty === 1'b1 && n < BIT) begin
      @(negedge clk);
      n++;
    end
    total++; if (n < 8 * DIV || n > 9 * DIV + 4) begin
      bad++; $display("FAIL single_latency got=%0d clocks want=%0d..%0d", n, 8 * DIV, 9 * DIV + 4);
    end
    total++; if (ifc.RdData !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", ifc.RdData); end
    total++; if (ifc.Count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d want=1", ifc.Count); end
    wait_clks(BIT);
    total++; if (ferr_n + perr_n + ovr_n !== f0) begin bad++; $display("FAIL single_flags got=%0d want=%0d", ferr_n + perr_n + ovr_n, f0); end
    ifc.RdEn = 1'b1;
    @(negedge clk);
    ifc.RdEn = 1'b0;
    total++; if (ifc.Empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b want=1", ifc.Empty); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_n + perr_n + ovr_n;
    @(negedge clk);
    rx = 1'b0;
    wait_clks(5 * DIV);
    total++; if (ifc.Busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b want=1", ifc.Busy); end
    rx = 1'b1;
    wait_clks(16 * DIV);
    total++; if (ifc.Busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_drop got=%b want=0", ifc.Busy); end
    total++; if (ifc.Empty !== 1'b1) begin bad++; $display("FAIL glitch_empty got=%b want=1", ifc.Empty); end
    total++; if (ferr_n + perr_n + ovr_n !== f0) begin bad++; $display("FAIL glitch_flags got=%0d want=%0d", ferr_n + perr_n + ovr_n, f0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_n;
    send_head(8'h3C);
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(BIT);
    total++; if (ferr_n - f0 !== 1) begin bad++; $display("FAIL frame_err_pulses got=%0d want=1", ferr_n - f0); end
    total++; if (ifc.Count !== 5'd0) begin bad++; $display("FAIL frame_err_count got=%0d want=0", ifc.Count); end
    send_frame(8'h5A);
    total++; if (ifc.Count !== 5'd1 || ifc.RdData !== 8'h5A) begin
      bad++; $display("FAIL frame_err_next got=%0d/%h want=1/5a", ifc.Count, ifc.RdData);
    end
    ifc.RdEn = 1'b1;
    @(negedge clk);
    ifc.RdEn = 1'b0;
  endtask

  task automatic test_overrun();
    int o0;
    logic [DB-1:0] e;
    o0 = ovr_n;
    exp_q.delete();
    exp_ovr = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i));
      model_rx(8'(i));
      if (i == 15) begin
        total++; if (ifc.Full !== 1'b1) begin bad++; $display("FAIL overrun_full got=%b want=1", ifc.Full); end
      end
    end
    total++; if (ovr_n - o0 !== exp_ovr) begin bad++; $display("FAIL overrun_pulses got=%0d want=%0d", ovr_n - o0, exp_ovr); end
    total++; if (ifc.Count !== 5'(exp_q.size())) begin bad++; $display("FAIL overrun_count got=%0d want=%0d", ifc.Count, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (ifc.Empty !== 1'b0 || ifc.RdData !== e) begin
        bad++; $display("FAIL overrun_drain got=%h want=%h", ifc.RdData, e);
      end
      ifc.RdEn = 1'b1;
      @(negedge clk);
      ifc.RdEn = 1'b0;
    end
    total++; if (ifc.Empty !== 1'b1) begin bad++; $display("FAIL overrun_final_empty got=%b want=1", ifc.Empty); end
  endtask

  task automatic test_pop_on_push();
    int o0;
    int n;
    logic [DB-1:0] e;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i));
      model_rx(8'(i));
    end
    o0 = ovr_n;
    send_head(8'h10);
    rx = 1'b1;
    n = 0;
    @(negedge clk);
    while (ifc.Busy === 1'b1 && n < BIT) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= BIT) begin bad++; $display("FAIL pop_push_timeout got=%0d clocks want<%0d", n, BIT); end
    e = exp_q.pop_front();
    exp_q.push_back(8'h10);
    total++; if (ifc.RdData !== e) begin bad++; $display("FAIL pop_push_head got=%h want=%h", ifc.RdData, e); end
    ifc.RdEn = 1'b1;
    @(negedge clk);
    ifc.RdEn = 1'b0;
    wait_clks(BIT);
    total++; if (ovr_n - o0 !== 0) begin bad++; $display("FAIL pop_push_overrun got=%0d want=0", ovr_n - o0); end
    total++; if (ifc.Count !== 5'd16) begin bad++; $display("FAIL pop_push_count got=%0d want=16", ifc.Count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (ifc.RdData !== e) begin bad++; $display("FAIL pop_push_drain got=%h want=%h", ifc.RdData, e); end
      ifc.RdEn = 1'b1;
      @(negedge clk);
      ifc.RdEn = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] d;
    logic [DB-1:0] e;
    int k;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d);
      model_rx(d);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k && exp_q.size() > 0; j++) begin
        e = exp_q.pop_front();
        total++; if (ifc.RdData !== e) begin bad++; $display("FAIL b2b_data got=%h want=%h", ifc.RdData, e); end
        ifc.RdEn = 1'b1;
        @(negedge clk);
        ifc.RdEn = 1'b0;
      end
    end
    total++; if (ifc.Count !== 5'(exp_q.size())) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", ifc.Count, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (ifc.RdData !== e) begin bad++; $display("FAIL b2b_drain got=%h want=%h", ifc.RdData, e); end
      ifc.RdEn = 1'b1;
      @(negedge clk);
      ifc.RdEn = 1'b0;
    end
    // Reading an empty FIFO must not move anything.
    ifc.RdEn = 1'b1;
    wait_clks(3);
    ifc.RdEn = 1'b0;
    total++; if (ifc.Count !== 5'd0 || ifc.Empty !== 1'b1) begin
      bad++; $display("FAIL empty_read got=%0d/%b want=0/1", ifc.Count, ifc.Empty);
    end
    d = 8'($urandom_range(0, 255));
    send_frame(d);
    total++; if (ifc.RdData !== d || ifc.Count !== 5'd1) begin
      bad++; $display("FAIL empty_read_next got=%h/%0d want=%h/1", ifc.RdData, ifc.Count, d);
    end
    ifc.RdEn = 1'b1;
    @(negedge clk);
    ifc.RdEn = 1'b0;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    p0 = perr_n;
    par_flip = 1'b1;
    send_frame(8'h07);
    total++; if (perr_n - p0 !== 1 || ifc.Count !== 5'd0) begin
      bad++; $display("FAIL parity_07 got=%0d/%0d want=1/0", perr_n - p0, ifc.Count);
    end
    send_frame(8'h03);
    total++; if (perr_n - p0 !== 2 || ifc.Count !== 5'd0) begin
      bad++; $display("FAIL parity_03_bad got=%0d/%0d want=2/0", perr_n - p0, ifc.Count);
    end
    par_flip = 1'b0;
    send_frame(8'h03);
    total++; if (perr_n - p0 !== 2 || ifc.Count !== 5'd1 || ifc.RdData !== 8'h03) begin
      bad++; $display("FAIL parity_03_good got=%0d/%0d/%h want=2/1/03", perr_n - p0, ifc.Count, ifc.RdData);
    end
    ifc.RdEn = 1'b1;
    @(negedge clk);
    ifc.RdEn = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int f0;
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(3 * BIT + BIT / 2);
    total++; if (ifc.Busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", ifc.Busy); end
    rst = 1'b1;
    wait_clks(2);
    total++; if (ifc.Busy !== 1'b0 || ifc.Empty !== 1'b1 || ifc.Count !== 5'd0 || ifc.RdData !== 8'h00) begin
      bad++; $display("FAIL rstmid_outputs got=%b/%b/%0d/%h want=0/1/0/00", ifc.Busy, ifc.Empty, ifc.Count, ifc.RdData);
    end
    rst = 1'b0;
    exp_q.delete();
    wait_clks(8 * BIT);
    f0 = ferr_n + perr_n + ovr_n;
    send_frame(8'h81);
    total++; if (ifc.Count !== 5'd1 || ifc.RdData !== 8'h81) begin
      bad++; $display("FAIL rstmid_next got=%0d/%h want=1/81", ifc.Count, ifc.RdData);
    end
    total++; if (ferr_n + perr_n + ovr_n !== f0) begin bad++; $display("FAIL rstmid_flags got=%0d want=%0d", ferr_n + perr_n + ovr_n, f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_pop_on_push();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
